// File: rtl/ahb_src_slave_if.sv
// ahb_src_slave_if
// AHB-Lite slave front end on the source clock domain of the AHB-to-AHB bridge.
// Turns AHB address/data-phase transfers into the bridge request interface
// (valid / rd0_wr1 / addr / wr_data, answered by ready / rd_data / rd_valid).
// Writes are posted through the single request register; reads hold HREADYOUT
// low until the read response comes back.
//
// Optional build macro AHB_SRC_ERR_RESP_EN: when defined, transfers that are
// not 32-bit word sized and word aligned are not forwarded and get a two-cycle
// AHB ERROR response instead. When undefined, HSIZE is ignored and o_hresp is 0.

module ahb_src_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk_src,
    input  logic                  i_rstn_src,
    input  logic                  i_hsel,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hsize,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    input  logic                  i_hready,
    output logic                  o_hreadyout,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hresp,
    output logic                  o_valid,
    output logic                  o_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_rd_valid
);

    typedef enum logic [2:0] {
        IDLE,
        WR_DP,
        RD_DP,
        RD_REQ,
        RD_WAIT,
        RD_DONE,
        ERR1,
        ERR2
    } state_t;

    state_t                state;
    state_t                accept_state;
    logic                  accept;
    logic                  xfer_bad;
    logic                  xfer_fwd;
    logic [ADDR_WIDTH-1:0] addr_q;

    assign accept   = i_hsel & i_hready & i_htrans[1];
    assign xfer_fwd = accept & ~xfer_bad;

`ifdef AHB_SRC_ERR_RESP_EN
    assign xfer_bad = (i_hsize != 3'b010) | (i_haddr[1:0] != 2'b00);
    assign o_hresp  = (state == ERR1) | (state == ERR2);
`else
    logic unused_hsize;
    assign xfer_bad     = 1'b0;
    assign o_hresp      = 1'b0;
    assign unused_hsize = ^i_hsize;
`endif

    // Next state chosen by the address phase seen while this slave is ready.
    always_comb begin
        accept_state = IDLE;
        if (accept) begin
`ifdef AHB_SRC_ERR_RESP_EN
            if (xfer_bad)
                accept_state = ERR1;
            else
`endif
            if (i_hwrite)
                accept_state = WR_DP;
            else
                accept_state = RD_DP;
        end
    end

    // HREADYOUT from registered state; in a write data phase the refill waits
    // for the registered valid to clear, so a drain and refill never share a cycle.
    always_comb begin
        case (state)
            IDLE, RD_DONE, ERR2: o_hreadyout = 1'b1;
            WR_DP:               o_hreadyout = ~o_valid;
            default:             o_hreadyout = 1'b0;
        endcase
    end

    // Request FSM: address capture, write posting, ordered read issue and response wait.
    always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
        if (!i_rstn_src) begin
            state     <= IDLE;
            addr_q    <= '0;
            o_hrdata  <= '0;
            o_valid   <= 1'b0;
            o_rd0_wr1 <= 1'b1;
            o_addr    <= '0;
            o_wr_data <= '0;
        end else begin
            if (o_valid && i_ready && o_rd0_wr1)
                o_valid <= 1'b0;

            if (o_hreadyout && xfer_fwd)
                addr_q <= i_haddr;

            case (state)
                IDLE, RD_DONE: begin
                    state <= accept_state;
                end
                WR_DP: begin
                    if (o_hreadyout) begin
                        o_wr_data <= i_hwdata;
                        o_addr    <= addr_q;
                        o_rd0_wr1 <= 1'b1;
                        o_valid   <= 1'b1;
                        state     <= accept_state;
                    end
                end
                RD_DP: begin
                    if (!o_valid) begin
                        o_valid   <= 1'b1;
                        o_rd0_wr1 <= 1'b0;
                        o_addr    <= addr_q;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (o_valid && i_ready) begin
                        o_valid   <= 1'b0;
                        o_rd0_wr1 <= 1'b1;
                        if (i_rd_valid) begin
                            o_hrdata <= i_rd_data;
                            state    <= RD_DONE;
                        end else begin
                            state    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (i_rd_valid) begin
                        o_hrdata <= i_rd_data;
                        state    <= RD_DONE;
                    end
                end
`ifdef AHB_SRC_ERR_RESP_EN
                ERR1: begin
                    state <= ERR2;
                end
                ERR2: begin
                    state <= accept_state;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_src_slave_if.sv
// tb_ahb_src_slave_if
// Scoreboard bench for ahb_src_slave_if: an AHB-Lite master model feeds
// transfers, expected bridge requests and read data are queued as transfers
// are driven, and popped when the DUT handshakes a request or finishes a
// data phase. A small responder returns read data a fixed number of cycles
// after each read handshake. Honours AHB_SRC_ERR_RESP_EN when defined.

`timescale 1ns/1ps

module tb_ahb_src_slave_if;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AHB_SRC_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic          sel;
        logic [1:0]    trans;
        logic          wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            waits;
    } xfer_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic          i_clk_src = 1'b0;
    logic          i_rstn_src;
    logic          i_hsel;
    logic [AW-1:0] i_haddr;
    logic [1:0]    i_htrans;
    logic          i_hwrite;
    logic [2:0]    i_hsize;
    logic [DW-1:0] i_hwdata;
    logic          i_hready;
    logic          o_hreadyout;
    logic [DW-1:0] o_hrdata;
    logic          o_hresp;
    logic          o_valid;
    logic          o_rd0_wr1;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wr_data;
    logic          i_ready;
    logic [DW-1:0] i_rd_data;
    logic          i_rd_valid;

    xfer_t         xfer_q[$];
    req_t          req_q[$];
    logic [DW-1:0] resp_q[$];

    xfer_t         ap;
    xfer_t         dp;
    bit            ap_valid;
    bit            dp_valid;
    bit            dp_err;
    int            dp_waits;
    int            checks;
    int            errors;
    int            cyc;
    int            rd_lat;
    int            rsp_cnt;
    logic [DW-1:0] rsp_data;
    int            ready_block;
    bit            ready_rand;
    bit            chk_wr_lat;
    int            last_wr_done;
    bit            prev_stall;
    req_t          prev_req;
    bit            rd_hs_seen;

    ahb_src_slave_if #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .i_clk_src  (i_clk_src),
        .i_rstn_src (i_rstn_src),
        .i_hsel     (i_hsel),
        .i_haddr    (i_haddr),
        .i_htrans   (i_htrans),
        .i_hwrite   (i_hwrite),
        .i_hsize    (i_hsize),
        .i_hwdata   (i_hwdata),
        .i_hready   (i_hready),
        .o_hreadyout(o_hreadyout),
        .o_hrdata   (o_hrdata),
        .o_hresp    (o_hresp),
        .o_valid    (o_valid),
        .o_rd0_wr1  (o_rd0_wr1),
        .o_addr     (o_addr),
        .o_wr_data  (o_wr_data),
        .i_ready    (i_ready),
        .i_rd_data  (i_rd_data),
        .i_rd_valid (i_rd_valid)
    );

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign i_hready = o_hreadyout;

    // Source-domain clock, 100 MHz.
    always #5 i_clk_src = ~i_clk_src;

    // Hard stop in case a bounded loop is ever mis-sized.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_err(input xfer_t x);
        return ERR_EN && x.sel && x.trans[1] && ((x.size != 3'b010) || (x.addr[1:0] != 2'b00));
    endfunction

    function automatic xfer_t mk_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [2:0] sz, input int w);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = 1'b1; x.addr = a; x.size = sz;
        x.wdata = d; x.rdata = '0; x.waits = w;
        return x;
    endfunction

    function automatic xfer_t mk_rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [2:0] sz, input int w);
        xfer_t x;
        x.sel = 1'b1; x.trans = 2'b10; x.wr = 1'b0; x.addr = a; x.size = sz;
        x.wdata = '0; x.rdata = d; x.waits = w;
        return x;
    endfunction

    function automatic xfer_t mk_idle(input logic s, input logic [1:0] t);
        xfer_t x;
        x.sel = s; x.trans = t; x.wr = 1'b0; x.addr = 32'h0000_5000; x.size = 3'b010;
        x.wdata = '0; x.rdata = '0; x.waits = -1;
        return x;
    endfunction

    task automatic apply_stimulus(input xfer_t x);
        xfer_q.push_back(x);
    endtask

    task automatic drive_address(input xfer_t x, input bit act);
        i_hsel   = act ? x.sel : 1'b0;
        i_htrans = act ? x.trans : 2'b00;
        i_hwrite = act ? x.wr : 1'b0;
        i_haddr  = act ? x.addr : '0;
        i_hsize  = act ? x.size : 3'b010;
    endtask

    // One clock: sample mid-cycle, score requests and data phases, then
    // advance the AHB pipeline, i_ready and the read responder after the edge.
    task automatic step_cycle();
        bit   rdy;
        bit   have;
        req_t e;
        xfer_t nx;
        @(negedge i_clk_src);
        rdy = o_hreadyout;

        if (!o_valid)
            check_output("rd0_wr1_idle_high", o_rd0_wr1, 1'b1);
        if (prev_stall) begin
            check_output("hold_valid", o_valid, 1'b1);
            check_output("hold_rd0_wr1", o_rd0_wr1, prev_req.wr);
            check_output("hold_addr", o_addr, prev_req.addr);
            check_output("hold_wr_data", o_wr_data, prev_req.data);
        end

        if (o_valid && i_ready) begin
            have = (req_q.size() != 0);
            check_output("req_expected", have, 1'b1);
            if (have) begin
                e = req_q.pop_front();
                check_output("req_rd0_wr1", o_rd0_wr1, e.wr);
                check_output("req_addr", o_addr, e.addr);
                if (e.wr) begin
                    check_output("req_wr_data", o_wr_data, e.data);
                    if (chk_wr_lat)
                        check_output("wr_valid_latency", cyc - last_wr_done, 1);
                end
            end
            if (!o_rd0_wr1) begin
                rd_hs_seen = 1'b1;
                if (resp_q.size() != 0)
                    rsp_data = resp_q.pop_front();
                rsp_cnt = rd_lat;
            end
        end
        prev_stall    = o_valid && !i_ready;
        prev_req.wr   = o_rd0_wr1;
        prev_req.addr = o_addr;
        prev_req.data = o_wr_data;

        if (dp_valid) begin
            check_output("hresp", o_hresp, dp_err);
            if (!rdy) begin
                dp_waits++;
            end else begin
                if (dp.waits >= 0)
                    check_output("wait_states", dp_waits, dp.waits);
                if (!dp.wr && !dp_err)
                    check_output("hrdata", o_hrdata, dp.rdata);
                if (dp.wr)
                    last_wr_done = cyc;
            end
        end

        @(posedge i_clk_src);
        #1;
        cyc++;

        if (rdy) begin
            dp_valid = ap_valid;
            dp       = ap;
            dp_err   = ap_valid && is_err(ap);
            dp_waits = 0;
            i_hwdata = (ap_valid && ap.wr) ? ap.wdata : '0;
            if (xfer_q.size() != 0) begin
                nx       = xfer_q.pop_front();
                ap       = nx;
                ap_valid = nx.sel && nx.trans[1];
                drive_address(nx, 1'b1);
                if (ap_valid && !is_err(nx)) begin
                    req_q.push_back('{wr: nx.wr, addr: nx.addr, data: (nx.wr ? nx.wdata : '0)});
                    if (!nx.wr)
                        resp_q.push_back(nx.rdata);
                end
            end else begin
                ap_valid = 1'b0;
                drive_address(ap, 1'b0);
            end
        end

        if (ready_block > 0) begin
            i_ready = 1'b0;
            ready_block--;
        end else if (ready_rand) begin
            i_ready = 1'($urandom_range(0, 1));
        end else begin
            i_ready = 1'b1;
        end

        i_rd_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                i_rd_valid = 1'b1;
                i_rd_data  = rsp_data;
            end
        end
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        bit timed_out;
        n = 0;
        timed_out = 1'b0;
        while (xfer_q.size() != 0 || ap_valid || dp_valid || req_q.size() != 0 ||
               rsp_cnt > 0 || o_valid || !o_hreadyout) begin
            if (n >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
            step_cycle();
            n++;
        end
        check_output("drain_timeout", timed_out, 1'b0);
    endtask

    task automatic check_reset_values();
        check_output("rst_hreadyout", o_hreadyout, 1'b1);
        check_output("rst_hrdata", o_hrdata, '0);
        check_output("rst_hresp", o_hresp, 1'b0);
        check_output("rst_valid", o_valid, 1'b0);
        check_output("rst_rd0_wr1", o_rd0_wr1, 1'b1);
        check_output("rst_addr", o_addr, '0);
        check_output("rst_wr_data", o_wr_data, '0);
    endtask

    initial begin
        int n;
        xfer_t x;
        checks = 0; errors = 0; cyc = 0; rd_lat = 3; rsp_cnt = 0; rsp_data = '0;
        ready_block = 0; ready_rand = 1'b0; chk_wr_lat = 1'b0; last_wr_done = 0;
        prev_stall = 1'b0; rd_hs_seen = 1'b0; ap_valid = 1'b0; dp_valid = 1'b0;
        dp_err = 1'b0; dp_waits = 0;
        ap = mk_idle(1'b0, 2'b00); dp = ap;
        prev_req = '{wr: 1'b1, addr: '0, data: '0};
        i_rstn_src = 1'b0; i_ready = 1'b1; i_rd_valid = 1'b0; i_rd_data = '0; i_hwdata = '0;
        drive_address(ap, 1'b0);

        $display("[TB] reset");
        step_cycle();
        step_cycle();
        check_reset_values();
        i_rstn_src = 1'b1;
        step_cycle();

        $display("[TB] single write, zero wait states");
        chk_wr_lat = 1'b1;
        apply_stimulus(mk_wr(32'h0000_1000, 32'hDEAD_BEEF, 3'b010, 0));
        run_until_idle(40);
        chk_wr_lat = 1'b0;

        $display("[TB] back-to-back writes with controller stalled");
        ready_block = 5;
        apply_stimulus(mk_wr(32'h0000_1100, 32'h1111_AAAA, 3'b010, 0));
        apply_stimulus(mk_wr(32'h0000_1104, 32'h2222_BBBB, 3'b010, 4));
        run_until_idle(60);

        $display("[TB] read with delayed response");
        rd_lat = 3;
        apply_stimulus(mk_rd(32'h0000_2004, 32'h1234_5678, 3'b010, 5));
        run_until_idle(60);

        $display("[TB] write then read pipelined, controller stalled");
        ready_block = 4;
        apply_stimulus(mk_wr(32'h0000_1200, 32'h5A5A_0001, 3'b010, -1));
        apply_stimulus(mk_rd(32'h0000_2100, 32'h0BAD_F00D, 3'b010, -1));
        run_until_idle(80);

        $display("[TB] ignored transfers and unaligned/narrow accesses");
        apply_stimulus(mk_idle(1'b1, 2'b01));
        apply_stimulus(mk_idle(1'b0, 2'b10));
        apply_stimulus(mk_rd(32'h0000_3002, 32'h3333_0002, 3'b010, ERR_EN ? 1 : -1));
        apply_stimulus(mk_wr(32'h0000_3010, 32'h0000_00EE, 3'b000, ERR_EN ? 1 : -1));
        apply_stimulus(mk_rd(32'h0000_3020, 32'h7777_8888, 3'b010, -1));
        run_until_idle(80);

        $display("[TB] random mix with random controller ready");
        ready_rand = 1'b1;
        rd_lat = 2;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: x = mk_wr({$urandom_range(0, 255), 2'b00}, $urandom, 3'b010, -1);
                1: x = mk_rd({$urandom_range(0, 255), 2'b00}, $urandom, 3'b010, -1);
                default: x = mk_idle(1'b1, 2'b00);
            endcase
            apply_stimulus(x);
        end
        run_until_idle(600);
        ready_rand = 1'b0;

        $display("[TB] reset while waiting for read response");
        rd_lat = 8;
        rd_hs_seen = 1'b0;
        apply_stimulus(mk_rd(32'h0000_4000, 32'hCAFE_F00D, 3'b010, -1));
        n = 0;
        while (!rd_hs_seen && n < 50) begin
            step_cycle();
            n++;
        end
        check_output("rd_hs_before_reset", rd_hs_seen, 1'b1);
        step_cycle();
        step_cycle();
        check_output("rd_wait_hreadyout", o_hreadyout, 1'b0);
        i_rstn_src = 1'b0;
        #1;
        check_reset_values();
        xfer_q.delete();
        req_q.delete();
        resp_q.delete();
        ap_valid = 1'b0;
        dp_valid = 1'b0;
        prev_stall = 1'b0;
        drive_address(ap, 1'b0);
        step_cycle();
        i_rstn_src = 1'b1;
        n = 0;
        while (rsp_cnt > 0 && n < 20) begin
            step_cycle();
            n++;
        end
        step_cycle();
        check_output("late_rd_valid_hrdata", o_hrdata, '0);
        check_output("late_rd_valid_hreadyout", o_hreadyout, 1'b1);
        check_output("late_rd_valid_valid", o_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
